// File: rtl/deserializer.sv
`default_nettype none
// ============================================================================
// Module      : deserializer
// Description : Serial-to-parallel receiver. Shifts in one bit per enabled
//               clock edge and assembles WIDTH bits into a word, which is
//               presented in a one-entry holding register until the consumer
//               acknowledges it. A sticky flag records any completed word
//               that replaced an unacknowledged one.
//
// Parameters  : WIDTH     - word width in bits (>= 2)
//               MSB_FIRST - 1: first bit received lands in out_data[WIDTH-1]
//                           0: first bit received lands in out_data[0]
//
// Ports       : in_clock    - clock, rising edge active
//               in_reset    - asynchronous active-high reset
//               in_enable   - in_bit is valid and consumed on this edge
//               in_bit      - serial data bit
//               in_clear    - abort the partial word, clear out_overrun
//               in_read     - consumer acknowledges out_data
//               out_data    - last completed word (registered)
//               out_valid   - out_data holds an unacknowledged word
//               out_overrun - sticky: a word replaced an unacknowledged one
//               out_busy    - a partial word is in progress
//
// Revision    : 1.0 - initial release
// ============================================================================

module deserializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             in_clock,
    input  logic             in_reset,
    input  logic             in_enable,
    input  logic             in_bit,
    input  logic             in_clear,
    input  logic             in_read,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_overrun,
    output logic             out_busy
);

    localparam int                 c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    // Receive state is fully implied by the bit counter: zero means no
    // partial word is held, anything else means a word is being assembled.
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SHIFT = 1'b1;

    logic [WIDTH-1:0]   r_sr;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_data;
    logic               r_valid;
    logic               r_overrun;

    logic [WIDTH-1:0]   w_shifted;
    logic               w_take;
    logic               w_complete;
    logic [0:0]         w_state;

    logic [WIDTH-1:0]   w_sr_next;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [WIDTH-1:0]   w_data_next;
    logic               w_valid_next;
    logic               w_overrun_next;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shifted = {r_sr[WIDTH-2:0], in_bit};
        end else begin : g_lsb_first
            assign w_shifted = {in_bit, r_sr[WIDTH-1:1]};
        end
    endgenerate

    // Clear wins over shifting: the bit presented with a clear is dropped.
    assign w_take     = in_enable & ~in_clear;
    assign w_complete = w_take & (r_cnt == c_LAST);
    assign w_state    = (r_cnt != '0) ? c_ST_SHIFT : c_ST_IDLE;

    always_comb begin
        w_sr_next      = r_sr;
        w_cnt_next     = r_cnt;
        w_data_next    = r_data;
        w_valid_next   = r_valid;
        w_overrun_next = r_overrun;

        if (w_take) begin
            w_sr_next = w_shifted;
        end

        if (in_clear) begin
            w_cnt_next = '0;
        end else if (w_take) begin
            w_cnt_next = w_complete ? '0 : (r_cnt + 1'b1);
        end

        if (w_complete) begin
            w_data_next  = w_shifted;
            // A read on the completion edge acknowledges the old word, so the
            // new one simply takes its place and stays valid.
            w_valid_next = 1'b1;
        end else if (in_read && r_valid) begin
            w_valid_next = 1'b0;
        end

        if (in_clear) begin
            w_overrun_next = 1'b0;
        end else if (w_complete && r_valid && !in_read) begin
            w_overrun_next = 1'b1;
        end
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            r_sr      <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_sr      <= w_sr_next;
            r_cnt     <= w_cnt_next;
            r_data    <= w_data_next;
            r_valid   <= w_valid_next;
            r_overrun <= w_overrun_next;
        end
    end

    assign out_data    = r_data;
    assign out_valid   = r_valid;
    assign out_overrun = r_overrun;
    assign out_busy    = (w_state == c_ST_SHIFT);

endmodule

`default_nettype wire
